// File: rtl/mc_core_pkg.sv
// Shared definitions for the multi-cycle core: opcodes, instruction field
// positions and the sequencing FSM state encoding.
package mc_core_pkg;

  localparam logic [5:0] OP_ADD  = 6'd0;
  localparam logic [5:0] OP_SUB  = 6'd1;
  localparam logic [5:0] OP_AND  = 6'd2;
  localparam logic [5:0] OP_OR   = 6'd3;
  localparam logic [5:0] OP_SLT  = 6'd4;
  localparam logic [5:0] OP_ADDI = 6'd5;
  localparam logic [5:0] OP_LW   = 6'd6;
  localparam logic [5:0] OP_SW   = 6'd7;
  localparam logic [5:0] OP_BEQ  = 6'd8;
  localparam logic [5:0] OP_BNE  = 6'd9;
  localparam logic [5:0] OP_J    = 6'd10;
  localparam logic [5:0] OP_HALT = 6'd63;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RS1_HI = 25;
  localparam int RS1_LO = 21;
  localparam int RS2_HI = 20;
  localparam int RS2_LO = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  // Register-register ALU ops take rs2 as the second operand.
  function automatic logic is_rtype(input logic [5:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/mc_core_if.sv
// Instruction- and data-memory req/ack bus between the core and its memories.
interface mc_core_if #(
  parameter int XLEN = 32,
  parameter int PC_W = 16
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic            dmem_req;
  logic            dmem_we;
  logic [PC_W-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic            dmem_ack;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output imem_req, imem_addr, input imem_ack, imem_rdata,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, input dmem_ack, dmem_rdata
  );

  modport slave (
    input imem_req, imem_addr, output imem_ack, imem_rdata,
    input dmem_req, dmem_we, dmem_addr, dmem_wdata, output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mc_core_regfile.sv
// NREGS x XLEN register file: two combinational read ports, one synchronous
// write port, register 0 reads as zero and ignores writes.
module mc_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] regs_r [NREGS];

  assign rdata1 = (raddr1 == {AW{1'b0}}) ? {XLEN{1'b0}} : regs_r[raddr1];
  assign rdata2 = (raddr2 == {AW{1'b0}}) ? {XLEN{1'b0}} : regs_r[raddr2];

  // Register storage: cleared on reset, single write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
    end else if (we && (waddr != {AW{1'b0}})) begin
      regs_r[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/mc_core.sv
// Multi-cycle core: FETCH/DECODE/EXEC/MEM/WB sequenced over one shared ALU,
// with req/ack handshakes so slow instruction/data memories stall the core.
module mc_core
  import mc_core_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int PC_W  = 16,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  mc_core_if.master       bus,
  output logic [PC_W-1:0] pc_o,
  output logic            retire,
  output logic            halted
);

  localparam int AW = $clog2(NREGS);
  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  state_t          state_r, state_nx;
  logic [PC_W-1:0] pc_r, pc_nx, pc_inc_s, pc_br_s, pc_j_s;
  logic [31:0]     instr_r;
  logic [XLEN-1:0] opa_r, opb_r, res_r;
  logic [XLEN-1:0] imm_x_s, alu_b_s, alu_y_s, rdata1_s, rdata2_s;
  logic [5:0]      op_s;
  logic [4:0]      rs1_s, rs2_s, rd_s;
  logic [15:0]     imm_s;
  logic [AW-1:0]   waddr_s;
  logic            imem_req_r, dmem_req_r, dmem_we_r, halted_r;
  logic [PC_W-1:0] dmem_addr_r;
  logic [XLEN-1:0] dmem_wdata_r;
  logic            retire_s, rf_we_s, imem_hs_s, dmem_hs_s;

  function automatic logic [XLEN-1:0] alu(input logic [5:0] op,
                                          input logic [XLEN-1:0] a,
                                          input logic [XLEN-1:0] b);
    logic [XLEN-1:0] y;
    case (op)
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_SLT:  y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      default: y = a + b;
    endcase
    return y;
  endfunction

  assign op_s    = instr_r[OP_HI:OP_LO];
  assign rs1_s   = instr_r[RS1_HI:RS1_LO];
  assign rs2_s   = instr_r[RS2_HI:RS2_LO];
  assign rd_s    = instr_r[RD_HI:RD_LO];
  assign imm_s   = instr_r[IMM_HI:IMM_LO];
  assign imm_x_s = {{(XLEN-16){imm_s[15]}}, imm_s};
  assign alu_b_s = is_rtype(op_s) ? opb_r : imm_x_s;
  assign alu_y_s = alu(op_s, opa_r, alu_b_s);
  // ADDI and LW name their destination in the rs2 field.
  assign waddr_s = ((op_s == OP_ADDI) || (op_s == OP_LW)) ? rs2_s[AW-1:0] : rd_s[AW-1:0];

  assign pc_inc_s = pc_r + PC_ONE;
  assign pc_br_s  = pc_inc_s + imm_x_s[PC_W-1:0];
  assign pc_j_s   = PC_W'(imm_s);

  assign imem_hs_s = imem_req_r & bus.imem_ack;
  assign dmem_hs_s = dmem_req_r & bus.dmem_ack;

  mc_regfile #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) u_rf (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (rs1_s[AW-1:0]),
    .raddr2 (rs2_s[AW-1:0]),
    .rdata1 (rdata1_s),
    .rdata2 (rdata2_s),
    .we     (rf_we_s),
    .waddr  (waddr_s),
    .wdata  (res_r)
  );

  // Next-state, pc update, retire and register-write decisions.
  always_comb begin
    state_nx = state_r;
    pc_nx    = pc_r;
    retire_s = 1'b0;
    rf_we_s  = 1'b0;
    case (state_r)
      S_FETCH: begin
        if (imem_hs_s) state_nx = S_DECODE;
        else           state_nx = S_FETCH;
      end
      S_DECODE: state_nx = S_EXEC;
      S_EXEC: begin
        case (op_s)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_ADDI: state_nx = S_WB;
          OP_LW, OP_SW: state_nx = S_MEM;
          OP_BEQ: begin
            retire_s = 1'b1;
            pc_nx    = (opa_r == opb_r) ? pc_br_s : pc_inc_s;
            state_nx = S_FETCH;
          end
          OP_BNE: begin
            retire_s = 1'b1;
            pc_nx    = (opa_r != opb_r) ? pc_br_s : pc_inc_s;
            state_nx = S_FETCH;
          end
          OP_J: begin
            retire_s = 1'b1;
            pc_nx    = pc_j_s;
            state_nx = S_FETCH;
          end
          default: state_nx = S_HALT;
        endcase
      end
      S_MEM: begin
        if (dmem_hs_s) begin
          if (dmem_we_r) begin
            retire_s = 1'b1;
            pc_nx    = pc_inc_s;
            state_nx = S_FETCH;
          end else begin
            state_nx = S_WB;
          end
        end else begin
          state_nx = S_MEM;
        end
      end
      S_WB: begin
        rf_we_s  = 1'b1;
        retire_s = 1'b1;
        pc_nx    = pc_inc_s;
        state_nx = S_FETCH;
      end
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_HALT;
    endcase
  end

  // State, pc and request/halt outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_FETCH;
      pc_r       <= {PC_W{1'b0}};
      imem_req_r <= 1'b0;
      dmem_req_r <= 1'b0;
      halted_r   <= 1'b0;
    end else begin
      state_r    <= state_nx;
      pc_r       <= pc_nx;
      imem_req_r <= (state_nx == S_FETCH);
      dmem_req_r <= (state_nx == S_MEM);
      halted_r   <= (state_nx == S_HALT);
    end
  end

  // Datapath registers: instruction, operands, result and data-bus holding regs.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_r      <= 32'd0;
      opa_r        <= {XLEN{1'b0}};
      opb_r        <= {XLEN{1'b0}};
      res_r        <= {XLEN{1'b0}};
      dmem_we_r    <= 1'b0;
      dmem_addr_r  <= {PC_W{1'b0}};
      dmem_wdata_r <= {XLEN{1'b0}};
    end else begin
      case (state_r)
        S_FETCH: if (imem_hs_s) instr_r <= bus.imem_rdata;
        S_DECODE: begin
          opa_r <= rdata1_s;
          opb_r <= rdata2_s;
        end
        S_EXEC: begin
          res_r <= alu_y_s;
          if ((op_s == OP_LW) || (op_s == OP_SW)) begin
            dmem_addr_r  <= alu_y_s[PC_W-1:0];
            dmem_wdata_r <= opb_r;
            dmem_we_r    <= (op_s == OP_SW);
          end
        end
        S_MEM: if (dmem_hs_s && !dmem_we_r) res_r <= bus.dmem_rdata;
        default: ;
      endcase
    end
  end

  assign bus.imem_req   = imem_req_r;
  assign bus.imem_addr  = pc_r;
  assign bus.dmem_req   = dmem_req_r;
  assign bus.dmem_we    = dmem_we_r;
  assign bus.dmem_addr  = dmem_addr_r;
  assign bus.dmem_wdata = dmem_wdata_r;
  assign pc_o           = pc_r;
  assign retire         = retire_s & ~rst;
  assign halted         = halted_r;

endmodule
